shift_frame_sequencer: RTL and testbench
========================================

# shift_frame_sequencer

Controller that sequences an external serial-in/serial-out shift register of DEPTH stages as a serial loopback channel. It accepts one parallel word per frame over a valid/ready handshake and serialises it MSB-first onto the register's serial input. It then flushes the register and reassembles the word from the serial output into a parallel result, flagged with a one-cycle valid pulse. It sits between a parallel producer/consumer and the shift-register datapath, and owns that register's shift enable exclusively.

## Interface
- WIDTH, 8: bits per frame; minimum 2.
- DEPTH, 4: stage count of the attached shift register (si-to-so latency in enabled clocks); minimum 1.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- tx_data  input  WIDTH  word to send; sampled on handshake.
- tx_valid  input  1  producer has a word.
- tx_ready  output  1  sequencer can accept a word.
- sr_en  output  1  shift enable to the shift register; it advances on clk edges where sr_en=1.
- sr_si  output  1  serial data to the shift register input.
- sr_so  input  1  serial data from the shift register output.
- rx_data  output  WIDTH  reassembled word; holds until the next frame completes.
- rx_valid  output  1  one-cycle pulse: rx_data is new.
- busy  output  1  high in any state other than IDLE.

## Operation
- States: IDLE, SHIFT, FLUSH, DONE. All outputs decode from registers only; no combinational path from any input to any output.
- **IDLE:**
  - tx_ready=1, sr_en=0.
  - On tx_valid&&tx_ready: load tx_data into the shadow register, clear the counter, go to SHIFT.
- **SHIFT:**
  - sr_en=1; sr_si = shadow MSB.
  - Shadow shifts left by one each cycle.
  - Stays WIDTH cycles, then goes to FLUSH.
- **FLUSH:**
  - sr_en=1, sr_si=0.
  - Stays DEPTH cycles, then goes to DONE.
- **Capture:**
  - Enabled cycles are numbered 1..WIDTH+DEPTH from the first SHIFT cycle.
  - On enabled cycles DEPTH+1..DEPTH+WIDTH, do rx_shift <= {rx_shift[WIDTH-2:0], sr_so}.
  - Exactly WIDTH samples are taken. Register contents that predate the frame are never sampled.
- **DONE:**
  - rx_data <= rx_shift; rx_valid=1 for this single cycle.
  - sr_en=0, tx_ready=0; go to IDLE.
- tx_valid is ignored outside IDLE, and tx_data may change freely once accepted.
- A single counter of width $clog2(WIDTH+DEPTH+1) serves both SHIFT and FLUSH. It is cleared on every state entry.
- **Reset values:**
  - state=IDLE, tx_ready=1, sr_en=0, sr_si=0, busy=0, rx_valid=0.
  - rx_data=0, shadow=0, counter=0.
- **Reset mid-frame:** the frame is aborted immediately and asynchronously. There is no rx_valid for it, and the shift-register contents are left undefined. The first frame after reset is correct regardless of leftover register contents.

## Timing
- Handshake at edge of cycle 0 → SHIFT occupies cycles 1..WIDTH.
- FLUSH occupies cycles WIDTH+1..WIDTH+DEPTH.
- DONE is cycle WIDTH+DEPTH+1, where rx_valid=1.
- IDLE is cycle WIDTH+DEPTH+2, with tx_ready=1.
- Frame period is WIDTH+DEPTH+2 cycles when tx_valid is held continuously.
- sr_si bit k (MSB = k=0) is driven in cycle k+1 and appears on sr_so in cycle k+1+DEPTH.
- rx_valid and tx_ready are never both high.

## Structure
- Package shift_seq_pkg holds:
  - the state enum typedef (IDLE, SHIFT, FLUSH, DONE), 2-bit encoding;
  - a counter-width function, cnt_w(WIDTH, DEPTH).
- No sub-module is needed in RTL.
- The bench instantiates a DEPTH-stage SISO shift-register model, named sr_model, with an enable pin. Its ports are clk, reset, en, si and so, and it connects sr_si→si and so→sr_so.

## Test plan
- **Basic frame**, WIDTH=8, DEPTH=4, tx_data=0xA5:
  - sr_si in cycles 1..8 = 1,0,1,0,0,1,0,1;
  - sr_en high in cycles 1..12;
  - rx_valid in cycle 13 only, with rx_data=0xA5.
- **Back-to-back**, tx_valid held with 0x3C then 0xFF:
  - second handshake in cycle 14;
  - rx_valid in cycles 13 and 27 with rx_data 0x3C and 0xFF;
  - tx_ready low in cycles 1..13.
- **Stale register**, model preloaded with 1111, tx_data=0x00 → rx_data=0x00; no preload bit leaks into the word.
- **Reset mid-frame**: reset=0 in cycle 5 of frame 0x5A:
  - immediately sr_en=0, busy=0, tx_ready=1;
  - no rx_valid for that frame.
  - After release, frame 0x0F yields rx_data=0x0F.
- **Parameter corners:**
  - WIDTH=2, DEPTH=1: tx_data=2'b10 → rx_valid in cycle 4, rx_data=2'b10.
  - WIDTH=16, DEPTH=8: tx_data=0x8001 → rx_valid in cycle 25, rx_data=0x8001.
- **Busy-time input changes**: tx_valid pulsed and tx_data changed while busy → ignored; rx_data equals the originally accepted word.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// Shared types and helpers for the shift-register frame sequencer.
package shift_seq_pkg;

  // Frame sequencing phases.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Width of the phase counter: it must reach WIDTH+DEPTH, the highest
  // enabled-cycle index within a frame.
  function automatic int cnt_w(input int width, input int depth);
    return $clog2(width + depth + 1);
  endfunction

endpackage

// File: rtl/shift_frame_sequencer.sv
// Drives an external DEPTH-stage SISO shift register as a serial loopback:
// one parallel word goes out MSB-first, the register is flushed, and the
// word is rebuilt from the serial output and presented with a valid pulse.
//
// Handshake: a word transfers on a rising edge where tx_valid and tx_ready
// are both high; tx_ready is only high in IDLE, so tx_valid/tx_data are
// ignored at all other times. rx_valid is a single-cycle pulse with no
// back-pressure; rx_data holds its value until the next frame completes.
module shift_frame_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             sr_en,
  output logic             sr_si,
  input  logic             sr_so,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             busy
);

  localparam int CW = cnt_w(WIDTH, DEPTH);

  localparam logic [CW-1:0] SHIFT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] FLUSH_LAST = CW'(DEPTH - 1);
  localparam logic [CW-1:0] CAP_FIRST  = CW'(DEPTH + 1);
  localparam logic [CW-1:0] WIDTH_C    = CW'(WIDTH);
  localparam logic [CW-1:0] ONE_C      = CW'(1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic [CW-1:0]    en_idx;
  logic             capture;

  // State register; reset aborts any frame in flight at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: SHIFT lasts WIDTH cycles, FLUSH lasts DEPTH cycles.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (tx_valid) state_d = SHIFT;
      SHIFT:   if (cnt_q == SHIFT_LAST) state_d = FLUSH;
      FLUSH:   if (cnt_q == FLUSH_LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode from registered state and shadow only.
  always_comb begin
    tx_ready = (state_q == IDLE);
    busy     = (state_q != IDLE);
    sr_en    = (state_q == SHIFT) || (state_q == FLUSH);
    sr_si    = (state_q == SHIFT) ? shadow_q[WIDTH-1] : 1'b0;
    rx_valid = (state_q == DONE);
    rx_data  = rx_data_q;
  end

  // Datapath next values: counter, outgoing shadow, incoming capture.
  always_comb begin
    // Counter restarts on every phase change and rests at zero in IDLE.
    if ((state_d != state_q) || (state_q == IDLE)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + ONE_C;
    end

    // 1-based index of the current enabled cycle within the frame.
    en_idx = (state_q == FLUSH) ? (WIDTH_C + cnt_q + ONE_C) : (cnt_q + ONE_C);

    // Bits reaching sr_so before index DEPTH+1 are leftovers from before
    // the frame, so sampling starts only once the first sent bit arrives.
    capture = sr_en && (en_idx >= CAP_FIRST);

    shadow_d = shadow_q;
    if ((state_q == IDLE) && tx_valid) begin
      shadow_d = tx_data;
    end else if (state_q == SHIFT) begin
      shadow_d = {shadow_q[WIDTH-2:0], 1'b0};
    end

    rx_shift_d = capture ? {rx_shift_q[WIDTH-2:0], sr_so} : rx_shift_q;

    // The last sample lands on the FLUSH->DONE edge, so publish the
    // updated value there to have rx_data valid alongside rx_valid.
    rx_data_d = ((state_q == FLUSH) && (state_d == DONE)) ? rx_shift_d : rx_data_q;
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q      <= '0;
      shadow_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
    end else begin
      cnt_q      <= cnt_d;
      shadow_q   <= shadow_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
    end
  end

endmodule

// File: tb/tb_shift_frame_sequencer.sv
// Bench for shift_frame_sequencer with an attached SISO shift-register model.

// DEPTH-stage SISO shift register. Reset fills it with ones so every frame
// that follows a reset runs against stale, non-zero contents.
module sr_model #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic si,
  output logic so
);
  logic [DEPTH-1:0] stg;

  // Advance one stage per enabled clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stg <= '1;
    end else if (en) begin
      stg <= (stg << 1) | DEPTH'(si);
    end
  end

  assign so = stg[DEPTH-1];
endmodule

module tb_shift_frame_sequencer;
  localparam int W   = 8;
  localparam int D   = 4;
  localparam int TOT = W + D + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT (8/4) ----------------
  logic [W-1:0] tx_data = '0;
  logic         tx_valid = 1'b0;
  logic         tx_ready, sr_en, sr_si, sr_so, rx_valid, busy;
  logic [W-1:0] rx_data;

  shift_frame_sequencer #(.WIDTH(W), .DEPTH(D)) u_dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .sr_en(sr_en), .sr_si(sr_si), .sr_so(sr_so),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy)
  );
  sr_model #(.DEPTH(D)) u_sr (
    .clk(clk), .reset(reset), .en(sr_en), .si(sr_si), .so(sr_so)
  );

  // ---------------- corner DUT (2/1) ----------------
  logic [1:0] c2_data = '0;
  logic       c2_valid = 1'b0;
  logic       c2_ready, c2_en, c2_si, c2_so, c2_rv, c2_busy;
  logic [1:0] c2_rx;

  shift_frame_sequencer #(.WIDTH(2), .DEPTH(1)) u_dut2 (
    .clk(clk), .reset(reset), .tx_data(c2_data), .tx_valid(c2_valid),
    .tx_ready(c2_ready), .sr_en(c2_en), .sr_si(c2_si), .sr_so(c2_so),
    .rx_data(c2_rx), .rx_valid(c2_rv), .busy(c2_busy)
  );
  sr_model #(.DEPTH(1)) u_sr2 (
    .clk(clk), .reset(reset), .en(c2_en), .si(c2_si), .so(c2_so)
  );

  // ---------------- corner DUT (16/8) ----------------
  logic [15:0] c16_data = '0;
  logic        c16_valid = 1'b0;
  logic        c16_ready, c16_en, c16_si, c16_so, c16_rv, c16_busy;
  logic [15:0] c16_rx;

  shift_frame_sequencer #(.WIDTH(16), .DEPTH(8)) u_dut16 (
    .clk(clk), .reset(reset), .tx_data(c16_data), .tx_valid(c16_valid),
    .tx_ready(c16_ready), .sr_en(c16_en), .sr_si(c16_si), .sr_so(c16_so),
    .rx_data(c16_rx), .rx_valid(c16_rv), .busy(c16_busy)
  );
  sr_model #(.DEPTH(8)) u_sr16 (
    .clk(clk), .reset(reset), .en(c16_en), .si(c16_si), .so(c16_so)
  );

  // ---------------- check bookkeeping ----------------
  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model of the main DUT ----------------
  // A frame is described only by the accepted word and the cycle offset
  // from its handshake: offsets 1..W send the word, 1..W+D keep the
  // register enabled, W+D+1 delivers the word back.
  logic [W-1:0] exp_q[$];
  bit           m_act  = 1'b0;
  int           m_off  = 0;
  logic [W-1:0] m_word = '0;
  logic [W-1:0] m_rx   = '0;

  // Advance the model on the same edges as the DUT.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_act <= 1'b0;
      m_off <= 0;
      m_rx  <= '0;
      exp_q.delete();
    end else if (m_act) begin
      if (m_off == TOT) begin
        m_act <= 1'b0;
      end else begin
        m_off <= m_off + 1;
        if (m_off + 1 == TOT) m_rx <= exp_q.pop_front();
      end
    end else if (tx_valid) begin
      m_act  <= 1'b1;
      m_off  <= 1;
      m_word <= tx_data;
      exp_q.push_back(tx_data);
    end
  end

  // Per-cycle compare of every main DUT output against the model.
  always @(negedge clk) begin
    logic e_en, e_si, e_rv;
    e_en = m_act && (m_off <= W + D);
    e_si = (m_act && (m_off <= W)) ? m_word[W - m_off] : 1'b0;
    e_rv = m_act && (m_off == TOT);
    check("cyc_tx_ready", 32'(tx_ready), 32'(!m_act));
    check("cyc_busy",     32'(busy),     32'(m_act));
    check("cyc_sr_en",    32'(sr_en),    32'(e_en));
    check("cyc_sr_si",    32'(sr_si),    32'(e_si));
    check("cyc_rx_valid", 32'(rx_valid), 32'(e_rv));
    check("cyc_rx_data",  32'(rx_data),  32'(m_rx));
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge with the DUT idle; returns at the negedge of
  // cycle 15 (handshake edge closes cycle 0).
  task automatic frame_main(input logic [W-1:0] w, input bit disturb,
                            output int rv_cyc, output int rv_n,
                            output logic [W-1:0] rxd, output logic [W-1:0] si_bits,
                            output int en_cnt, output int rdy_low);
    rv_cyc = -1; rv_n = 0; rxd = '0; si_bits = '0; en_cnt = 0; rdy_low = 0;
    tx_data  = w;
    tx_valid = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (c <= W) si_bits[W - c] = sr_si;
      en_cnt  += int'(sr_en);
      rdy_low += int'(!tx_ready);
      if (rx_valid) begin
        rv_n++;
        if (rv_cyc < 0) begin rv_cyc = c; rxd = rx_data; end
      end
      if (c == 1) tx_valid = 1'b0;
      if (disturb && c == 3) begin tx_valid = 1'b1; tx_data = ~w; end
      if (disturb && c == 4) tx_data = 8'h99;
      if (disturb && c == 5) tx_valid = 1'b0;
    end
  endtask

  // ---------------- stimulus ----------------
  int           rv_cyc, rv_n, en_cnt, rdy_low;
  logic [W-1:0] rxd, si_bits;
  int           rv1_c, rv2_c;
  logic [W-1:0] rv1_d, rv2_d;

  initial begin
    // Reset state.
    @(negedge clk);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_sr_en",    32'(sr_en),    32'd0);
    check("rst_sr_si",    32'(sr_si),    32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_data",  32'(rx_data),  32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Stale register: model holds 1111 after reset, word is zero.
    frame_main(8'h00, 1'b0, rv_cyc, rv_n, rxd, si_bits, en_cnt, rdy_low);
    check("stale_rv_cyc", 32'(rv_cyc), 32'd13);
    check("stale_rx",     32'(rxd),    32'h00);

    // Basic frame.
    frame_main(8'hA5, 1'b0, rv_cyc, rv_n, rxd, si_bits, en_cnt, rdy_low);
    check("basic_si_bits", 32'(si_bits), 32'hA5);
    check("basic_en_cnt",  32'(en_cnt),  32'd12);
    check("basic_rdy_low", 32'(rdy_low), 32'd13);
    check("basic_rv_cyc",  32'(rv_cyc),  32'd13);
    check("basic_rv_n",    32'(rv_n),    32'd1);
    check("basic_rx",      32'(rxd),     32'hA5);

    // Busy-time input changes are ignored.
    frame_main(8'hC3, 1'b1, rv_cyc, rv_n, rxd, si_bits, en_cnt, rdy_low);
    check("busy_rv_n", 32'(rv_n), 32'd1);
    check("busy_rx",   32'(rxd),  32'hC3);

    // Back-to-back with tx_valid held.
    rv1_c = -1; rv2_c = -1; rv1_d = '0; rv2_d = '0; rdy_low = 0; rv_n = 0;
    tx_data = 8'h3C; tx_valid = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 28; c++) begin
      @(negedge clk);
      if (c <= 13) rdy_low += int'(!tx_ready);
      if (c == 14) check("b2b_ready_c14", 32'(tx_ready), 32'd1);
      if (rx_valid) begin
        rv_n++;
        if (rv1_c < 0) begin rv1_c = c; rv1_d = rx_data; end
        else begin rv2_c = c; rv2_d = rx_data; end
      end
      if (c == 1) tx_data = 8'hFF;
      if (c == 15) tx_valid = 1'b0;
    end
    check("b2b_rdy_low", 32'(rdy_low), 32'd13);
    check("b2b_rv_n",    32'(rv_n),    32'd2);
    check("b2b_rv1_cyc", 32'(rv1_c),   32'd13);
    check("b2b_rv1_rx",  32'(rv1_d),   32'h3C);
    check("b2b_rv2_cyc", 32'(rv2_c),   32'd27);
    check("b2b_rv2_rx",  32'(rv2_d),   32'hFF);

    // Reset in cycle 5 of a frame.
    tx_data = 8'h5A; tx_valid = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) tx_valid = 1'b0;
    end
    #2 reset = 1'b0;
    #1;
    check("mid_rst_sr_en",    32'(sr_en),    32'd0);
    check("mid_rst_busy",     32'(busy),     32'd0);
    check("mid_rst_tx_ready", 32'(tx_ready), 32'd1);
    rv_n = 0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      rv_n += int'(rx_valid);
      if (c == 3) reset = 1'b1;
    end
    check("mid_rst_no_rv", 32'(rv_n), 32'd0);
    frame_main(8'h0F, 1'b0, rv_cyc, rv_n, rxd, si_bits, en_cnt, rdy_low);
    check("after_rst_rv_cyc", 32'(rv_cyc), 32'd13);
    check("after_rst_rx",     32'(rxd),    32'h0F);

    // Corner WIDTH=2, DEPTH=1.
    rv_cyc = -1; rv_n = 0; rxd = '0;
    c2_data = 2'b10; c2_valid = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) c2_valid = 1'b0;
      if (c2_rv) begin
        rv_n++;
        if (rv_cyc < 0) begin rv_cyc = c; rxd = W'(c2_rx); end
      end
    end
    check("w2_rv_cyc", 32'(rv_cyc), 32'd4);
    check("w2_rv_n",   32'(rv_n),   32'd1);
    check("w2_rx",     32'(rxd),    32'h2);

    // Corner WIDTH=16, DEPTH=8 (first frame since reset: stale ones).
    rv_cyc = -1; rv_n = 0; rv1_d = '0;
    c16_data = 16'h8001; c16_valid = 1'b1;
    @(posedge clk);
    begin
      logic [15:0] r16;
      r16 = '0;
      for (int c = 1; c <= 30; c++) begin
        @(negedge clk);
        if (c == 1) c16_valid = 1'b0;
        if (c16_rv) begin
          rv_n++;
          if (rv_cyc < 0) begin rv_cyc = c; r16 = c16_rx; end
        end
      end
      check("w16_rv_cyc", 32'(rv_cyc), 32'd25);
      check("w16_rv_n",   32'(rv_n),   32'd1);
      check("w16_rx",     32'(r16),    32'h8001);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
